core_ctrl: RTL and testbench

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl_pkg.sv | 31 +++
 rtl/ctrl_counter.sv | 46 ++++
 rtl/core_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_core_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared FSM state type and instruction-word bit map for core_ctrl
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRD,
        S_WKER,
        S_XRD,
        S_EXEC,
        S_DRAIN,
        S_FIN
    } state_e;

    localparam int INST_W      = 35;
    localparam int INST_ADDR_W = 11;

    localparam int INST_RELU     = 34;
    localparam int INST_ACC      = 33;
    localparam int INST_P_CEN    = 32;
    localparam int INST_P_WEN    = 31;
    localparam int INST_P_ADDR   = 20;
    localparam int INST_X_CEN    = 19;
    localparam int INST_X_WEN    = 18;
    localparam int INST_X_ADDR   = 7;
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_L0_RD    = 3;
    localparam int INST_L0_WR    = 2;
    localparam int INST_EXEC     = 1;
    localparam int INST_KLOAD    = 0;

endpackage

// File: rtl/ctrl_counter.sv
// rtl/ctrl_counter.sv - loadable up-counter with terminal-count flag
//
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset
//   load_i          : load load_val_i (takes priority over en_i)
//   load_val_i      : value loaded on load_i
//   en_i            : increment by one
//   term_i          : terminal value; tc_o is high while count_o == term_i
//   count_o, tc_o   : current count and terminal-count flag
module ctrl_counter #(
    parameter int W = 11
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - sequencer for one weight-load / execute / drain pass of the PE core
//
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   start                    : one-cycle pass request, honoured only in IDLE
//   w_base, x_base, p_base   : weight, activation and psum SRAM base addresses
//   n_vec                    : number of activation vectors (0 = empty pass)
//   relu_en, acc_en          : carried on inst[34:33] during DRAIN and FIN
//   ofifo_valid              : output FIFO holds a word to be written back
//   inst                     : 35-bit core instruction word
//   busy, done               : not-IDLE flag, end-of-pass pulse
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int row     = 8,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    input  logic [addr_bw-1:0] p_base,
    input  logic [addr_bw-1:0] n_vec,
    input  logic               relu_en,
    input  logic               acc_en,
    input  logic               ofifo_valid,
    output logic [INST_W-1:0]  inst,
    output logic               busy,
    output logic               done
);

    state_e state_q, state_d;

    logic [addr_bw-1:0] w_base_q, x_base_q, p_base_q, n_vec_q;
    logic               relu_q, acc_q;
    logic               rd_q;        // an xmem read was issued last cycle
    logic               latch_cfg;

    logic               xrd, pwr, l0rd, ex, kl, mode_out;
    logic [addr_bw-1:0] xa, pa;

    logic               cnt_load, cnt_en, cnt_tc, dcnt_en, dcnt_tc;
    logic [addr_bw-1:0] cnt, dcnt, cnt_term;

    // Both counters restart from zero on every state change.
    assign cnt_load = (state_d != state_q);

    ctrl_counter #(.W(addr_bw)) u_phase_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (cnt_load),
        .load_val_i ('0),
        .en_i       (cnt_en),
        .term_i     (cnt_term),
        .count_o    (cnt),
        .tc_o       (cnt_tc)
    );

    ctrl_counter #(.W(addr_bw)) u_drain_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (cnt_load),
        .load_val_i ('0),
        .en_i       (dcnt_en),
        .term_i     (n_vec_q - 1'b1),
        .count_o    (dcnt),
        .tc_o       (dcnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        latch_cfg = 1'b0;
        xrd       = 1'b0;
        xa        = '0;
        pwr       = 1'b0;
        pa        = '0;
        l0rd      = 1'b0;
        ex        = 1'b0;
        kl        = 1'b0;
        cnt_en    = 1'b0;
        dcnt_en   = 1'b0;
        cnt_term  = addr_bw'(row - 1);
        mode_out  = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    latch_cfg = 1'b1;
                    state_d   = (n_vec == '0) ? S_FIN : S_WRD;
                end
            end
            S_WRD: begin
                xrd    = 1'b1;
                xa     = w_base_q + cnt;
                cnt_en = 1'b1;
                if (cnt_tc) state_d = S_WKER;
            end
            S_WKER: begin
                // The first cycle only retires the last delayed l0_wr.
                if (!rd_q) begin
                    l0rd   = 1'b1;
                    kl     = 1'b1;
                    cnt_en = 1'b1;
                    if (cnt_tc) state_d = S_XRD;
                end
            end
            S_XRD: begin
                cnt_term = n_vec_q - 1'b1;
                xrd      = 1'b1;
                xa       = x_base_q + cnt;
                cnt_en   = 1'b1;
                if (cnt_tc) state_d = S_EXEC;
            end
            S_EXEC: begin
                cnt_term = n_vec_q - 1'b1;
                if (!rd_q) begin
                    l0rd   = 1'b1;
                    ex     = 1'b1;
                    cnt_en = 1'b1;
                    if (cnt_tc) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                mode_out = 1'b1;
                if (ofifo_valid) begin
                    pwr     = 1'b1;
                    pa      = p_base_q + dcnt;
                    dcnt_en = 1'b1;
                    if (dcnt_tc) state_d = S_FIN;
                end
            end
            S_FIN: begin
                mode_out = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rd_q     <= 1'b0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            n_vec_q  <= '0;
            relu_q   <= 1'b0;
            acc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= xrd;
            if (latch_cfg) begin
                w_base_q <= w_base;
                x_base_q <= x_base;
                p_base_q <= p_base;
                n_vec_q  <= n_vec;
                relu_q   <= relu_en;
                acc_q    <= acc_en;
            end
        end
    end

    always_comb begin
        inst = '0;
        inst[INST_RELU]                       = mode_out & relu_q;
        inst[INST_ACC]                        = mode_out & acc_q;
        inst[INST_P_CEN]                      = ~pwr;
        inst[INST_P_WEN]                      = ~pwr;
        inst[INST_P_ADDR +: INST_ADDR_W]      = INST_ADDR_W'(pa);
        inst[INST_X_CEN]                      = ~xrd;
        inst[INST_X_WEN]                      = 1'b1;
        inst[INST_X_ADDR +: INST_ADDR_W]      = INST_ADDR_W'(xa);
        inst[INST_OFIFO_RD]                   = pwr;
        inst[INST_L0_RD]                      = l0rd;
        inst[INST_L0_WR]                      = rd_q;
        inst[INST_EXEC]                       = ex;
        inst[INST_KLOAD]                      = kl;
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - self-checking bench for core_ctrl against a cycle-trace model
module tb_core_ctrl;
    import core_ctrl_pkg::*;

    localparam int ROW = 8;
    localparam int AW  = 11;

    logic          clk = 1'b0;
    logic          reset, start, relu_en, acc_en, ofifo_valid;
    logic [AW-1:0] w_base, x_base, p_base, n_vec;
    logic [34:0]   inst;
    logic          busy, done;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];
    bit          vv[1024];

    always #5 clk = ~clk;

    core_ctrl #(.row(ROW), .addr_bw(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .w_base      (w_base),
        .x_base      (x_base),
        .p_base      (p_base),
        .n_vec       (n_vec),
        .relu_en     (relu_en),
        .acc_en      (acc_en),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] mk(bit xr, logic [10:0] xa, bit pw, logic [10:0] pa,
                                       bit l0r, bit l0w, bit ex, bit kl, bit rl, bit ac);
        logic [34:0] w;
        w = '0;
        w[INST_RELU]     = rl;
        w[INST_ACC]      = ac;
        w[INST_P_CEN]    = !pw;
        w[INST_P_WEN]    = !pw;
        w[INST_P_ADDR +: 11] = pw ? pa : 11'd0;
        w[INST_X_CEN]    = !xr;
        w[INST_X_WEN]    = 1'b1;
        w[INST_X_ADDR +: 11] = xr ? xa : 11'd0;
        w[INST_OFIFO_RD] = pw;
        w[INST_L0_RD]    = l0r;
        w[INST_L0_WR]    = l0w;
        w[INST_EXEC]     = ex;
        w[INST_KLOAD]    = kl;
        return w;
    endfunction

    // Expected {inst, busy, done} for each cycle after start is accepted.
    task automatic build(input logic [10:0] w, x, p, n, input bit rl, ac);
        int j;
        exp_q.delete();
        if (n != 0) begin
            for (int k = 0; k < ROW; k++)
                exp_q.push_back({mk(1, w + 11'(k), 0, 0, 0, k > 0, 0, 0, 0, 0), 2'b10});
            exp_q.push_back({mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 2'b10});
            for (int k = 0; k < ROW; k++)
                exp_q.push_back({mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0), 2'b10});
            for (int k = 0; k < int'(n); k++)
                exp_q.push_back({mk(1, x + 11'(k), 0, 0, 0, k > 0, 0, 0, 0, 0), 2'b10});
            exp_q.push_back({mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 2'b10});
            for (int k = 0; k < int'(n); k++)
                exp_q.push_back({mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0), 2'b10});
            j = 0;
            while (j < int'(n)) begin
                if (vv[exp_q.size()]) begin
                    exp_q.push_back({mk(0, 0, 1, p + 11'(j), 0, 0, 0, 0, rl, ac), 2'b10});
                    j++;
                end else begin
                    exp_q.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0, rl, ac), 2'b10});
                end
            end
        end
        exp_q.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0, rl, ac), 2'b11});
        exp_q.push_back({mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00});
    endtask

    task automatic set_valid(input bit rnd);
        for (int i = 0; i < 1024; i++) vv[i] = (rnd && i < 200) ? 1'($urandom) : 1'b1;
    endtask

    task automatic run_pass(input string name, input logic [10:0] w, x, p, n,
                            input bit rl, ac, input int abort_at);
        build(w, x, p, n, rl, ac);
        w_base = w; x_base = x; p_base = p; n_vec = n;
        relu_en = rl; acc_en = ac; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w_base = 11'($urandom); x_base = 11'($urandom); p_base = 11'($urandom);
        n_vec = 11'($urandom); relu_en = 1'($urandom); acc_en = 1'($urandom);
        for (int c = 0; c < exp_q.size(); c++) begin
            ofifo_valid = vv[c];
            start = (c < exp_q.size() - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (c == abort_at) reset = 1'b1;
            @(negedge clk);
            check($sformatf("%s c%0d", name, c), {inst, busy, done}, exp_q[c]);
            @(posedge clk); #1;
            if (c == abort_at) begin
                reset = 1'b0;
                start = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check($sformatf("%s abort+%0d", name, i), {inst, busy, done},
                          {mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00});
                    @(posedge clk); #1;
                end
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; relu_en = 1'b0; acc_en = 1'b0; ofifo_valid = 1'b0;
        w_base = '0; x_base = '0; p_base = '0; n_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset", {inst, busy, done}, {35'h1_800C_0000, 2'b00});
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle", {inst, busy, done}, {35'h1_800C_0000, 2'b00});
        @(posedge clk); #1;

        set_valid(0);
        run_pass("basic", 11'h010, 11'h100, 11'h200, 11'd4, 0, 0, -1);

        set_valid(0);
        vv[26] = 1; vv[27] = 0; vv[28] = 0; vv[29] = 1; vv[30] = 1; vv[31] = 0; vv[32] = 1;
        run_pass("toggle", 11'h010, 11'h100, 11'h200, 11'd4, 0, 0, -1);

        set_valid(0);
        run_pass("pwrap", 11'h7FC, 11'h7FE, 11'h7FE, 11'd3, 0, 1, -1);

        run_pass("nvec0", 11'h123, 11'h456, 11'h789, 11'd0, 1, 1, -1);

        set_valid(1);
        run_pass("relu", 11'h000, 11'h040, 11'h080, 11'd5, 1, 0, -1);

        set_valid(0);
        run_pass("abort", 11'h010, 11'h100, 11'h200, 11'd4, 1, 1, 23);
        run_pass("after", 11'h020, 11'h300, 11'h400, 11'd2, 0, 1, -1);

        for (int t = 0; t < 12; t++) begin
            set_valid(1);
            run_pass($sformatf("rnd%0d", t), 11'($urandom), 11'($urandom), 11'($urandom),
                     11'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
